// File: rtl/seg7_pkg.sv
// Shared segment codes (A..G, A = MSB) and scroller state encoding.
// SEG_ACTIVE_LOW_EN selects the output polarity mask for common-anode digits.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_H     = 7'h37;
    localparam logic [6:0] SEG_L     = 7'h0E;
    localparam logic [6:0] SEG_O     = 7'h7E;
    localparam logic [6:0] SEG_P     = 7'h67;
    localparam logic [6:0] SEG_U     = 7'h3E;
    localparam logic [6:0] SEG_DASH  = 7'h01;
    localparam logic [6:0] SEG_BLANK = 7'h00;

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_POL = 7'h7F;
`else
    localparam logic [6:0] SEG_POL = 7'h00;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/ascii_to_seg7.sv
// Combinational ASCII to 7-segment lookup (A..G, active-high).
// Lowercase folds to uppercase; unsupported codes give a blank digit.
module ascii_to_seg7
    import seg7_pkg::*;
(
    input  logic [7:0] ch,
    output logic [6:0] seg
);

    logic [7:0] up;

    always_comb begin
        up = ch;
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            up = ch - 8'h20;
        end
        case (up)
            8'h30:   seg = SEG_0;
            8'h31:   seg = SEG_1;
            8'h32:   seg = SEG_2;
            8'h33:   seg = SEG_3;
            8'h34:   seg = SEG_4;
            8'h35:   seg = SEG_5;
            8'h36:   seg = SEG_6;
            8'h37:   seg = SEG_7;
            8'h38:   seg = SEG_8;
            8'h39:   seg = SEG_9;
            8'h41:   seg = SEG_A;
            8'h42:   seg = SEG_B;
            8'h43:   seg = SEG_C;
            8'h44:   seg = SEG_D;
            8'h45:   seg = SEG_E;
            8'h46:   seg = SEG_F;
            8'h48:   seg = SEG_H;
            8'h4C:   seg = SEG_L;
            8'h4F:   seg = SEG_O;
            8'h50:   seg = SEG_P;
            8'h55:   seg = SEG_U;
            8'h2D:   seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ascii_7seg_scroller.sv
// Scrolling multi-digit ASCII message display for 7-segment digits.
// Define SEG_ACTIVE_LOW_EN for inverted (common-anode) segment outputs.
module ascii_7seg_scroller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int MSG_LEN    = 16,
    parameter int SCROLL_DIV = 25_000_000
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Wr_En,
    input  logic [$clog2(MSG_LEN)-1:0] i_Wr_Addr,
    input  logic [7:0]                 i_Wr_Char,
    input  logic [$clog2(MSG_LEN):0]   i_Len,
    input  logic                       i_Start,
    input  logic                       i_Stop,
    input  logic                       i_Pause,
    output logic [7*NUM_DIGITS-1:0]    o_Segments,
    output logic                       o_Running,
    output logic                       o_Wrap
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(SCROLL_DIV);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MSG_LEN);
    localparam logic [TW-1:0] TICK_END = TW'(SCROLL_DIV - 1);

    state_t                  state;
    logic [7:0]              buffer [MSG_LEN];
    logic [LW-1:0]           len;
    logic [AW-1:0]           offset;
    logic [TW-1:0]           tick;
    logic                    wrap_q;
    logic [7*NUM_DIGITS-1:0] codes;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic [AW-1:0]           off_nxt;

    function automatic logic [AW-1:0] idx_inc(
        input logic [AW-1:0] cur,
        input logic [LW-1:0] n
    );
        return (({1'b0, cur} + LW'(1)) >= n) ? '0 : cur + AW'(1);
    endfunction

    function automatic logic [AW-1:0] win_idx(
        input logic [AW-1:0] off,
        input logic [LW-1:0] n,
        input int            k
    );
        logic [AW-1:0] r;
        r = off;
        for (int j = 0; j < k; j++) begin
            r = idx_inc(r, n);
        end
        return r;
    endfunction

    assign off_nxt = idx_inc(offset, len);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buffer[i] <= 8'h20;
            end
        end else if (i_Wr_En && ({1'b0, i_Wr_Addr} < LEN_MAX)) begin
            buffer[i_Wr_Addr] <= i_Wr_Char;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state  <= ST_IDLE;
            len    <= LEN_MAX;
            offset <= '0;
            tick   <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (i_Stop) begin
                state  <= ST_IDLE;
                offset <= '0;
                tick   <= '0;
            end else if (i_Start) begin
                state  <= ST_RUN;
                offset <= '0;
                tick   <= '0;
                len    <= (i_Len == '0 || i_Len > LEN_MAX) ? LEN_MAX : i_Len;
            end else if (state == ST_RUN && !i_Pause) begin
                if (tick == TICK_END) begin
                    tick   <= '0;
                    offset <= off_nxt;
                    wrap_q <= (off_nxt == '0);
                end else begin
                    tick <= tick + TW'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        logic [AW-1:0] idx;
        logic [6:0]    code;
        assign idx = win_idx(offset, len, k);
        ascii_to_seg7 u_dec (
            .ch  (buffer[idx]),
            .seg (code)
        );
        assign codes[7*k +: 7] = code;
    end

    // Stop blanks on the same edge it takes effect, not a cycle later.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Stop || state == ST_IDLE) begin
            seg_q <= {NUM_DIGITS{SEG_POL}};
        end else begin
            seg_q <= codes ^ {NUM_DIGITS{SEG_POL}};
        end
    end

    assign o_Segments = seg_q;
    assign o_Running  = (state == ST_RUN);
    assign o_Wrap     = wrap_q;

endmodule

// File: tb/tb_ascii_7seg_scroller.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_ascii_7seg_scroller;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Wr_En = 1'b0;
    logic [2:0]  i_Wr_Addr = '0;
    logic [7:0]  i_Wr_Char = '0;
    logic [3:0]  i_Len = '0;
    logic        i_Start = 1'b0;
    logic        i_Stop = 1'b0;
    logic        i_Pause = 1'b0;
    logic [13:0] o_Segments;
    logic        o_Running;
    logic        o_Wrap;

    ascii_7seg_scroller #(
        .NUM_DIGITS (2),
        .MSG_LEN    (8),
        .SCROLL_DIV (4)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Wr_En    (i_Wr_En),
        .i_Wr_Addr  (i_Wr_Addr),
        .i_Wr_Char  (i_Wr_Char),
        .i_Len      (i_Len),
        .i_Start    (i_Start),
        .i_Stop     (i_Stop),
        .i_Pause    (i_Pause),
        .o_Segments (o_Segments),
        .o_Running  (o_Running),
        .o_Wrap     (o_Wrap)
    );

    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [13:0] seg;
        logic        run;
        logic        wrap;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [13:0] win(input logic [6:0] d0,
                                        input logic [6:0] d1);
        return {d1, d0};
    endfunction

    task automatic push_exp(input int c, input logic [13:0] seg,
                            input logic run, input logic wrap,
                            input string name);
        exp_t x;
        int   pos;
        x.c = c;
        x.seg = seg;
        x.run = run;
        x.wrap = wrap;
        x.name = name;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].c > c) pos--;
        sb.insert(pos, x);
    endtask

    always @(negedge i_Clk) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.c < cyc) begin
                fails++;
                $display("FAIL %s: slot %0d missed at %0d", e.name, e.c, cyc);
            end else if (o_Segments !== e.seg || o_Running !== e.run ||
                         o_Wrap !== e.wrap) begin
                fails++;
                $display("FAIL %s @%0d: got seg=%h run=%b wrap=%b want seg=%h run=%b wrap=%b",
                         e.name, cyc, o_Segments, o_Running, o_Wrap,
                         e.seg, e.run, e.wrap);
            end
        end
    end

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] ch);
        i_Wr_En = 1'b1;
        i_Wr_Addr = a;
        i_Wr_Char = ch;
        step();
        i_Wr_En = 1'b0;
    endtask

    logic [13:0] hello [5];
    logic [13:0] full8 [8];
    string       msg;
    int          c0, s, s2, s3, guard;

    initial begin
        hello[0] = win(7'h37, 7'h4F);
        hello[1] = win(7'h4F, 7'h0E);
        hello[2] = win(7'h0E, 7'h0E);
        hello[3] = win(7'h0E, 7'h7E);
        hello[4] = win(7'h7E, 7'h37);
        for (int i = 0; i < 4; i++) full8[i] = hello[i];
        full8[4] = win(7'h7E, 7'h00);
        full8[5] = 14'h0;
        full8[6] = 14'h0;
        full8[7] = win(7'h00, 7'h37);

        step();
        step();
        i_Rst = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 10; i++) push_exp(c0 + i, 14'h0, 1'b0, 1'b0, "idle");
        repeat (10) step();

        msg = "HELLO";
        for (int i = 0; i < 5; i++) wr(3'(i), msg[i]);
        i_Len = 4'd5;
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        s = cyc;
        push_exp(s, 14'h0, 1'b1, 1'b0, "start_blank");
        for (int j = 0; j < 6; j++)
            push_exp(s + 1 + 4*j, hello[j % 5], 1'b1, 1'b0, "hello_win");
        push_exp(s + 20, hello[4], 1'b1, 1'b1, "wrap5");

        while (cyc < s + 28) step();
        i_Pause = 1'b1;
        push_exp(s + 29, hello[2], 1'b1, 1'b0, "pause_ll");
        push_exp(s + 40, hello[2], 1'b1, 1'b0, "pause_hold");
        push_exp(s + 44, hello[2], 1'b1, 1'b0, "resume_ll");
        push_exp(s + 45, hello[3], 1'b1, 1'b0, "resume_lo");
        while (cyc < s + 40) step();
        i_Pause = 1'b0;

        while (cyc < s + 45) step();
        i_Start = 1'b1;
        i_Stop = 1'b1;
        push_exp(s + 46, 14'h0, 1'b0, 1'b0, "stop_wins");
        push_exp(s + 48, 14'h0, 1'b0, 1'b0, "stop_idle");
        step();
        i_Start = 1'b0;
        i_Stop = 1'b0;
        step();
        step();

        i_Len = 4'd0;
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        s2 = cyc;
        for (int j = 0; j < 8; j++)
            push_exp(s2 + 1 + 4*j, full8[j], 1'b1, 1'b0, "len8_win");
        push_exp(s2 + 20, full8[4], 1'b1, 1'b0, "len8_nowrap");
        push_exp(s2 + 32, full8[7], 1'b1, 1'b1, "wrap8");

        while (cyc < s2 + 33) step();
        push_exp(s2 + 34, hello[0], 1'b1, 1'b0, "wr_z_pre");
        push_exp(s2 + 35, win(7'h37, 7'h00), 1'b1, 1'b0, "wr_z");
        wr(3'd1, 8'h7A);

        while (cyc < s2 + 37) step();
        push_exp(s2 + 38, win(7'h00, 7'h0E), 1'b1, 1'b0, "wr_7_pre");
        push_exp(s2 + 39, win(7'h70, 7'h0E), 1'b1, 1'b0, "wr_7");
        wr(3'd1, 8'h37);

        while (cyc < s2 + 41) step();
        push_exp(s2 + 43, win(7'h0E, 7'h1F), 1'b1, 1'b0, "wr_lower_b");
        wr(3'd3, 8'h62);

        while (cyc < s2 + 44) step();
        push_exp(s2 + 45, 14'h0, 1'b0, 1'b0, "mid_reset");
        i_Rst = 1'b1;
        step();
        i_Rst = 1'b0;
        i_Len = 4'd0;
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        s3 = cyc;
        for (int j = 0; j < 8; j++)
            push_exp(s3 + 1 + 4*j, 14'h0, 1'b1, 1'b0, "cleared_buf");

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            step();
            guard++;
        end
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL timeout: %0d expectations left", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
